// File: rtl/rsa_pkg.sv
// Shared types and constants for the RSA datapath blocks.
// Montgomery multiplier FSM states and word-count helper.
package rsa_pkg;

    localparam int WORD = 32;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        MUL_AB    = 3'd1,
        RED_M     = 3'd2,
        RED_N     = 3'd3,
        FINAL_SUB = 3'd4,
        DONE      = 3'd5
    } mm_state_t;

    function automatic int words(input int width);
        return width / WORD;
    endfunction

endpackage

// File: rtl/montgomery_mult_word_mac.sv
// Combinational 32x32 multiply with two 32-bit addends: {hi,lo} = x*y + p + c.
// The result always fits in 64 bits, since (2^32-1)^2 + 2*(2^32-1) = 2^64-1.
module word_mac
    import rsa_pkg::*;
(
    input  logic [WORD-1:0] x,
    input  logic [WORD-1:0] y,
    input  logic [WORD-1:0] p,
    input  logic [WORD-1:0] c,
    output logic [WORD-1:0] hi,
    output logic [WORD-1:0] lo
);

    logic [2*WORD-1:0] sum_s;

    assign sum_s = ({{WORD{1'b0}}, x} * {{WORD{1'b0}}, y})
                 + {{WORD{1'b0}}, p} + {{WORD{1'b0}}, c};
    assign hi = sum_s[2*WORD-1:WORD];
    assign lo = sum_s[WORD-1:0];

endmodule

// File: rtl/montgomery_mult.sv
// Word-serial CIOS Montgomery multiplier: result = a*b*2^-WIDTH mod n.
// One shared MAC; T is kept as S+2 words with the reduction shift folded into RED_N.
module montgomery_mult
    import rsa_pkg::*;
#(
    parameter int WIDTH = 1024
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] n,
    input  logic [31:0]      n0prime,
    output logic [WIDTH-1:0] result,
    output logic             busy,
    output logic             done
);

    localparam int S  = words(WIDTH);
    localparam int JW = $clog2(S + 1);
    localparam int TW = (S + 2) * WORD;

    mm_state_t         state_q, state_d;
    logic [JW-1:0]     i_q, i_d, j_q, j_d;
    logic [WORD-1:0]   c_q, c_d, m_q, m_d, np_q, np_d;
    logic              borrow_q, borrow_d;
    logic [TW-1:0]     t_q, t_d;
    logic [WIDTH-1:0]  a_q, a_d, b_q, b_d, n_q, n_d, d_q, d_d, result_q, result_d;
    logic              busy_q, busy_d, done_q, done_d;

    logic [WORD-1:0]   mx_s, my_s, mp_s, mc_s, hi_s, lo_s;
    logic [WORD-1:0]   a_w_s, b_w_s, n_w_s, t_w_s;
    logic [WORD:0]     sub_s;
    logic [31:0]       jb_s, jmb_s, ib_s;

    assign jb_s  = 32'(j_q) * 32'(WORD);
    assign jmb_s = jb_s - 32'(WORD);
    assign ib_s  = 32'(i_q) * 32'(WORD);
    assign a_w_s = a_q[jb_s +: WORD];
    assign b_w_s = b_q[ib_s +: WORD];
    assign n_w_s = n_q[jb_s +: WORD];
    assign t_w_s = t_q[jb_s +: WORD];
    assign sub_s = {1'b0, t_w_s} - {1'b0, n_w_s} - {{WORD{1'b0}}, borrow_q};

    word_mac u_mac (
        .x  (mx_s),
        .y  (my_s),
        .p  (mp_s),
        .c  (mc_s),
        .hi (hi_s),
        .lo (lo_s)
    );

    // Next-state, datapath and MAC operand selection
    always_comb begin
        state_d  = state_q;
        i_d      = i_q;
        j_d      = j_q;
        c_d      = c_q;
        m_d      = m_q;
        np_d     = np_q;
        borrow_d = borrow_q;
        t_d      = t_q;
        a_d      = a_q;
        b_d      = b_q;
        n_d      = n_q;
        d_d      = d_q;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        mx_s     = {WORD{1'b0}};
        my_s     = {WORD{1'b0}};
        mp_s     = {WORD{1'b0}};
        mc_s     = {WORD{1'b0}};
        case (state_q)
            IDLE: begin
                if (start) begin
                    a_d     = a;
                    b_d     = b;
                    n_d     = n;
                    np_d    = n0prime;
                    t_d     = {TW{1'b0}};
                    i_d     = {JW{1'b0}};
                    j_d     = {JW{1'b0}};
                    c_d     = {WORD{1'b0}};
                    busy_d  = 1'b1;
                    state_d = MUL_AB;
                end else begin
                    state_d = IDLE;
                end
            end
            MUL_AB: begin
                if (j_q == JW'(S)) begin
                    mp_s = t_q[S*WORD +: WORD];
                    mc_s = c_q;
                    t_d[S*WORD +: 2*WORD] = {hi_s, lo_s};
                    c_d     = {WORD{1'b0}};
                    j_d     = {JW{1'b0}};
                    state_d = RED_M;
                end else begin
                    mx_s = a_w_s;
                    my_s = b_w_s;
                    mp_s = t_w_s;
                    mc_s = c_q;
                    t_d[jb_s +: WORD] = lo_s;
                    c_d = hi_s;
                    j_d = j_q + JW'(1'b1);
                end
            end
            RED_M: begin
                mx_s    = t_q[WORD-1:0];
                my_s    = np_q;
                m_d     = lo_s;
                c_d     = {WORD{1'b0}};
                j_d     = {JW{1'b0}};
                state_d = RED_N;
            end
            RED_N: begin
                mp_s = t_w_s;
                mc_s = c_q;
                if (j_q == JW'(S)) begin
                    mp_s = t_q[S*WORD +: WORD];
                    t_d[(S-1)*WORD +: WORD] = lo_s;
                    t_d[S*WORD +: WORD]     = t_q[(S+1)*WORD +: WORD] + hi_s;
                    t_d[(S+1)*WORD +: WORD] = {WORD{1'b0}};
                    c_d = {WORD{1'b0}};
                    j_d = {JW{1'b0}};
                    if (i_q == JW'(S - 1)) begin
                        borrow_d = 1'b0;
                        state_d  = FINAL_SUB;
                    end else begin
                        i_d     = i_q + JW'(1'b1);
                        state_d = MUL_AB;
                    end
                end else begin
                    mx_s = m_q;
                    my_s = n_w_s;
                    c_d  = hi_s;
                    j_d  = j_q + JW'(1'b1);
                    // Word 0 of the sum is zero by choice of m; it is dropped, giving the shift.
                    if (j_q == {JW{1'b0}}) begin
                        t_d = t_q;
                    end else begin
                        t_d[jmb_s +: WORD] = lo_s;
                    end
                end
            end
            FINAL_SUB: begin
                d_d[jb_s +: WORD] = sub_s[WORD-1:0];
                borrow_d = sub_s[WORD];
                if (j_q == JW'(S - 1)) begin
                    j_d     = {JW{1'b0}};
                    state_d = DONE;
                end else begin
                    j_d = j_q + JW'(1'b1);
                end
            end
            DONE: begin
                if ((t_q[S*WORD +: WORD] != {WORD{1'b0}}) || !borrow_q) begin
                    result_d = d_q;
                end else begin
                    result_d = t_q[WIDTH-1:0];
                end
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            i_q      <= {JW{1'b0}};
            j_q      <= {JW{1'b0}};
            c_q      <= {WORD{1'b0}};
            m_q      <= {WORD{1'b0}};
            np_q     <= {WORD{1'b0}};
            borrow_q <= 1'b0;
            t_q      <= {TW{1'b0}};
            a_q      <= {WIDTH{1'b0}};
            b_q      <= {WIDTH{1'b0}};
            n_q      <= {WIDTH{1'b0}};
            d_q      <= {WIDTH{1'b0}};
            result_q <= {WIDTH{1'b0}};
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            i_q      <= i_d;
            j_q      <= j_d;
            c_q      <= c_d;
            m_q      <= m_d;
            np_q     <= np_d;
            borrow_q <= borrow_d;
            t_q      <= t_d;
            a_q      <= a_d;
            b_q      <= b_d;
            n_q      <= n_d;
            d_q      <= d_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
        end
    end

    assign result = result_q;
    assign busy   = busy_q;
    assign done   = done_q;

endmodule

// File: tb/tb_montgomery_mult.sv
// Scoreboarded bench for montgomery_mult at WIDTH=64 and WIDTH=1024.
// Expected values come from a*b mod n followed by WIDTH modular halvings.
module tb_montgomery_mult;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic          s_start, s_busy, s_done;
    logic [63:0]   s_a, s_b, s_n, s_res;
    logic [31:0]   s_np;
    logic          g_start, g_busy, g_done;
    logic [1023:0] g_a, g_b, g_n, g_res;
    logic [31:0]   g_np;

    montgomery_mult #(.WIDTH(64)) u_small (
        .clk(clk), .rst_n(rst_n), .start(s_start), .a(s_a), .b(s_b), .n(s_n),
        .n0prime(s_np), .result(s_res), .busy(s_busy), .done(s_done)
    );

    montgomery_mult #(.WIDTH(1024)) u_big (
        .clk(clk), .rst_n(rst_n), .start(g_start), .a(g_a), .b(g_b), .n(g_n),
        .n0prime(g_np), .result(g_res), .busy(g_busy), .done(g_done)
    );

    localparam logic [63:0] N64  = 64'hFFFFFFFFFFFFFFC5;
    localparam logic [31:0] NP64 = 32'hA08AD8F3;
    localparam int L64  = 17;
    localparam int L1K  = 2177;

    typedef struct {
        logic [1023:0] res;
        int            cyc;
    } exp_t;

    exp_t q_s[$];
    exp_t q_g[$];
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   ndone_s = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [1023:0] act, input logic [1023:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic logic [1023:0] mont_ref(input logic [1023:0] a, input logic [1023:0] b,
                                               input logic [1023:0] n, input int w);
        logic [2047:0] p;
        logic [2047:0] r;
        logic [1024:0] x;
        p = {1024'd0, a} * {1024'd0, b};
        r = p % {1024'd0, n};
        x = {1'b0, r[1023:0]};
        for (int k = 0; k < w; k++) begin
            if (x[0]) x = (x + {1'b0, n}) >> 1;
            else      x = x >> 1;
        end
        return x[1023:0];
    endfunction

    function automatic logic [31:0] n0p(input logic [31:0] n0);
        logic [31:0] inv;
        inv = n0;
        for (int k = 0; k < 5; k++) inv = inv * (32'd2 - n0 * inv);
        return 32'd0 - inv;
    endfunction

    task automatic issue(input bit big, input logic [1023:0] a, input logic [1023:0] b,
                         input logic [1023:0] n, input logic [31:0] np);
        if (big) begin
            g_a = a; g_b = b; g_n = n; g_np = np; g_start = 1'b1;
            q_g.push_back('{mont_ref(a, b, n, 1024), cyc + 1 + L1K});
        end else begin
            s_a = a[63:0]; s_b = b[63:0]; s_n = n[63:0]; s_np = np; s_start = 1'b1;
            q_s.push_back('{mont_ref(a, b, n, 64), cyc + 1 + L64});
        end
        @(negedge clk);
        s_start = 1'b0;
        g_start = 1'b0;
    endtask

    task automatic wait_done(input bit big);
        int k = 0;
        int lim = big ? 2400 : 100;
        while (!(big ? g_done : s_done) && k < lim) begin
            @(negedge clk);
            k++;
        end
        if (!(big ? g_done : s_done)) begin
            checks++;
            errors++;
            $display("FAIL timeout: no done within %0d cycles (big=%0d)", lim, big);
        end
    endtask

    // Monitor for the 64-bit instance
    initial begin
        bit prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            if (s_done) begin
                ndone_s++;
                check("done64_not_repeated", prev, 1'b0);
                if (q_s.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done64: done=1 with nothing outstanding, expected 0");
                end else begin
                    e = q_s.pop_front();
                    check("result64", s_res, e.res);
                    check("latency64", cyc, e.cyc);
                end
            end
            prev = s_done;
        end
    end

    // Monitor for the 1024-bit instance
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (g_done) begin
                if (q_g.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_done1k: done=1 with nothing outstanding, expected 0");
                end else begin
                    e = q_g.pop_front();
                    check("result1k", g_res, e.res);
                    check("latency1k", cyc, e.cyc);
                end
            end
        end
    end

    initial begin
        logic [63:0]   rn, ra, rb;
        logic [1023:0] bn, ba, bb;
        int            d0;
        s_start = 1'b0; s_a = 64'd0; s_b = 64'd0; s_n = 64'd0; s_np = 32'd0;
        g_start = 1'b0; g_a = 1024'd0; g_b = 1024'd0; g_n = 1024'd0; g_np = 32'd0;
        repeat (2) @(negedge clk);
        check("reset_result", s_res, 64'd0);
        check("reset_busy", s_busy, 1'b0);
        check("reset_done", s_done, 1'b0);
        rst_n = 1'b1;
        @(negedge clk);

        // R mod n times x maps back to x; busy covers the whole operation
        issue(1'b0, 1024'd59, 1024'h1234, {960'd0, N64}, NP64);
        for (int e = 1; e <= L64; e++) begin
            @(negedge clk);
            check("busy_window", s_busy, (e < L64));
        end
        check("known_result", s_res, 64'h1234);
        wait_done(1'b0);

        // Zero operand, then back-to-back start in the cycle after done
        issue(1'b0, 1024'd0, 1024'h1234, {960'd0, N64}, NP64);
        wait_done(1'b0);
        check("zero_result", s_res, 64'd0);
        issue(1'b0, 1024'd59, 1024'd59, {960'd0, N64}, NP64);
        wait_done(1'b0);
        check("b2b_result", s_res, 64'd59);

        // n-1 exercises the final-subtract selection
        issue(1'b0, {960'd0, N64 - 64'd1}, 1024'd59, {960'd0, N64}, NP64);
        wait_done(1'b0);
        check("nminus1_result", s_res, 64'hFFFFFFFFFFFFFFC4);

        // Starts while busy are ignored, and operand changes do not leak in
        d0 = ndone_s;
        issue(1'b0, 1024'd59, 1024'h1234, {960'd0, N64}, NP64);
        repeat (2) @(negedge clk);
        s_a = 64'd5; s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        repeat (6) @(negedge clk);
        s_a = 64'd7; s_start = 1'b1;
        @(negedge clk);
        s_start = 1'b0;
        wait_done(1'b0);
        repeat (20) @(negedge clk);
        check("single_done", ndone_s - d0, 1'b1);

        // Asynchronous reset mid-MUL_AB aborts the operation
        issue(1'b0, 1024'd59, 1024'd77, {960'd0, N64}, NP64);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_result", s_res, 64'd0);
        check("abort_busy", s_busy, 1'b0);
        check("abort_done", s_done, 1'b0);
        q_s.delete();
        @(negedge clk);
        rst_n = 1'b1;
        d0 = ndone_s;
        repeat (20) @(negedge clk);
        check("no_done_after_abort", ndone_s - d0, 1'b0);

        // Random 64-bit operands with random odd moduli
        for (int t = 0; t < 24; t++) begin
            rn = {$urandom, $urandom};
            rn[0] = 1'b1;
            rn[63] = 1'b1;
            ra = {$urandom, $urandom} % rn;
            rb = {$urandom, $urandom} % rn;
            issue(1'b0, {960'd0, ra}, {960'd0, rb}, {960'd0, rn}, n0p(rn[31:0]));
            wait_done(1'b0);
        end

        // Random 1024-bit operands
        for (int t = 0; t < 6; t++) begin
            for (int k = 0; k < 32; k++) begin
                bn[k*32 +: 32] = $urandom;
                ba[k*32 +: 32] = $urandom;
                bb[k*32 +: 32] = $urandom;
            end
            bn[0] = 1'b1;
            bn[1023] = 1'b1;
            ba = ba % bn;
            bb = bb % bn;
            issue(1'b1, ba, bb, bn, n0p(bn[31:0]));
            wait_done(1'b1);
        end
        repeat (3) @(negedge clk);
        check("queues_drained", 32'(q_s.size() + q_g.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
